i2c_accel_sequencer: RTL and testbench
======================================

// Module: i2c_accel_sequencer
// PURPOSE
//   Transaction sequencer that drives i2c_driver's command side. After reset it issues the
//   accelerometer init register writes. It then polls a 6-byte burst read of X/Y/Z at a fixed
//   interval and assembles the bytes into signed 16-bit samples for the display/logic stage.
// PARAMETERS
//   DEVICE_ADDR  7'h53  7-bit I2C slave address driven on deviceAddr
//   POLL_TICKS   1000   i2c_clock cycles between end of one read and start of next (>=1)
//   MAX_RETRY    3      consecutive NACKed attempts tolerated per transaction before ERROR
// PORTS
//   i2c_clock     in   1   clock shared with i2c_driver
//   reset         in   1   asynchronous, active-low reset
//   enable        in   1   level; 1 = run init/poll sequence
//   deviceAddr    out  7   slave address to driver (= DEVICE_ADDR)
//   addr          out  8   register address of current transaction
//   numBytes      out  3   byte count (1 for writes, 6 for reads)
//   wrData        out  8   write payload byte
//   write         out  1   1 = register write, 0 = burst read
//   start         out  1   one-cycle command strobe to driver
//   done          in   1   one-cycle completion pulse from driver
//   ack_error     in   1   valid with done; 1 = slave NACKed
//   rdData        in   48  read bytes, byte0 in [7:0] .. byte5 in [47:40]; valid with done
//   x_out,y_out,z_out out 16 signed samples, held between updates
//   sample_valid  out  1   one-cycle pulse when x/y/z update
//   busy          out  1   1 while a command is outstanding (start issued, done not yet seen)
//   error         out  1   sticky; 1 in ERROR state
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; start=0, write=0, addr=0, numBytes=0, wrData=0,
//     x/y/z=0, sample_valid=0, busy=0, error=0, init_done=0, retry=0, poll count=0.
//   Init table: entry0 {addr 8'h2D, data 8'h08}; entry1 {addr 8'h31, data 8'h0B}.
//   States:
//     IDLE:       enable=1 & !init_done -> INIT_ISSUE (idx=0); enable=1 & init_done -> READ_ISSUE.
//     INIT_ISSUE: drive write=1, numBytes=1, addr/wrData=table[idx]; start=1 for this cycle
//                 only -> INIT_WAIT.
//     INIT_WAIT:  wait for done. If ack_error & retry<MAX_RETRY: retry++, -> INIT_ISSUE
//                 with same idx. If ack_error & retry==MAX_RETRY -> ERROR.
//                 Otherwise retry=0, idx++; idx was 1 -> init_done=1, -> READ_ISSUE.
//     READ_ISSUE: write=0, addr=8'h32, numBytes=6, start=1 for one cycle -> READ_WAIT.
//     READ_WAIT:  on done. NACK uses the same retry rule as INIT_WAIT.
//                 On success: x={b1,b0}, y={b3,b2}, z={b5,b4}; sample_valid=1 next cycle;
//                 count=0 -> POLL_WAIT.
//     POLL_WAIT:  count++ each cycle; count==POLL_TICKS-1 -> READ_ISSUE.
//     ERROR:      error=1, no starts; leave only via reset or enable=0 (-> IDLE, error=0,
//                 init_done=0).
//   Command outputs (addr/numBytes/wrData/write) are registered. They are stable from the
//     ISSUE cycle until done.
//   busy=1 from the cycle after start through the done cycle inclusive.
//   done is ignored outside *_WAIT states. start is never asserted while busy=1.
//   enable=0 in a WAIT state: the transaction completes and results are stored. Then -> IDLE.
//   enable=0 in POLL_WAIT or IDLE: -> IDLE next cycle. init_done is kept, so re-enable
//     skips init.
//   Latency: done(read) -> x/y/z registered and sample_valid high on the next edge (1 cycle).
//   Sample registers hold their value through ERROR and IDLE until overwritten or reset.
// TESTING
//   1 Reset release, enable=1, driver model acks all -> two writes (2D/08, 31/0B), each
//     start 1 cycle wide, then read of 32/6 bytes.
//   2 Read returns bytes 34 12 CD AB 00 80 -> x=16'h1234, y=16'hABCD, z=16'h8000,
//     sample_valid high for exactly 1 cycle.
//   3 POLL_TICKS=5: cycles from read done to next start = 6 (1 transition + 5 poll).
//   4 NACK the first write twice, then ack -> 3 starts with identical addr/data, then
//     progress; with 4 NACKs -> error=1, no further starts.
//   5 enable dropped mid READ_WAIT -> no new start; done still updates x/y/z; re-enable ->
//     read issued directly, no init writes.
//   6 reset asserted mid INIT_WAIT -> all outputs return to reset values immediately,
//     without waiting for a clock edge.

Source files
------------

// File: rtl/i2c_accel_sequencer_if.sv
// Command/response bus between the accelerometer sequencer and i2c_driver.
// The master side issues register writes and burst reads. The slave side returns
// done, ack_error and read data.
interface i2c_accel_sequencer_if;
    logic [6:0]  deviceAddr;
    logic [7:0]  addr;
    logic [2:0]  numBytes;
    logic [7:0]  wrData;
    logic        write;
    logic        start;
    logic        done;
    logic        ack_error;
    logic [47:0] rdData;

    modport master (
        output deviceAddr, addr, numBytes, wrData, write, start,
        input  done, ack_error, rdData
    );

    modport slave (
        input  deviceAddr, addr, numBytes, wrData, write, start,
        output done, ack_error, rdData
    );
endinterface

// File: rtl/i2c_accel_sequencer.sv
// Accelerometer transaction sequencer.
// After enable, it writes the two init registers. It then polls a 6-byte X/Y/Z burst
// read at a fixed interval and assembles the bytes into 16-bit signed samples.
// A command that is NACKed is reissued up to MAX_RETRY times before the block parks in ERROR.
module i2c_accel_sequencer #(
    parameter logic [6:0] DEVICE_ADDR = 7'h53,
    parameter int         POLL_TICKS  = 1000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                  i2c_clock,
    input  logic                  reset,
    input  logic                  enable,
    i2c_accel_sequencer_if.master drv,
    output logic signed [15:0]    x_out,
    output logic signed [15:0]    y_out,
    output logic signed [15:0]    z_out,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  error
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int CW = (POLL_TICKS < 2) ? 1 : $clog2(POLL_TICKS);
    localparam logic [RW-1:0] MAX_R     = RW'(MAX_RETRY);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE, INIT_ISSUE, INIT_WAIT, READ_ISSUE, READ_WAIT, POLL_WAIT, ERROR
    } state_t;

    state_t          state, state_n;
    logic            idx, idx_n;
    logic [RW-1:0]   retry, retry_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            init_done, init_done_n;
    logic            start_q, start_n;
    logic            write_q, write_n;
    logic [7:0]      addr_q, addr_n;
    logic [2:0]      nbytes_q, nbytes_n;
    logic [7:0]      wrdata_q, wrdata_n;
    logic            smp_load;

    assign drv.deviceAddr = DEVICE_ADDR;
    assign drv.start      = start_q;
    assign drv.write      = write_q;
    assign drv.addr       = addr_q;
    assign drv.numBytes   = nbytes_q;
    assign drv.wrData     = wrdata_q;

    // Next-state, retry/poll bookkeeping, and command loading when an ISSUE state is entered
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        retry_n     = retry;
        cnt_n       = cnt;
        init_done_n = init_done;
        start_n     = 1'b0;
        write_n     = write_q;
        addr_n      = addr_q;
        nbytes_n    = nbytes_q;
        wrdata_n    = wrdata_q;
        smp_load    = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    if (init_done) begin
                        state_n = READ_ISSUE;
                    end else begin
                        idx_n   = 1'b0;
                        state_n = INIT_ISSUE;
                    end
                end
            end
            INIT_ISSUE: state_n = INIT_WAIT;
            READ_ISSUE: state_n = READ_WAIT;
            INIT_WAIT, READ_WAIT: begin
                if (drv.done) begin
                    if (drv.ack_error) begin
                        // When enable is low, the transaction is finished and no retry is issued.
                        if (!enable) begin
                            retry_n = '0;
                            state_n = IDLE;
                        end else if (retry < MAX_R) begin
                            retry_n = retry + 1'b1;
                            state_n = (state == INIT_WAIT) ? INIT_ISSUE : READ_ISSUE;
                        end else begin
                            state_n = ERROR;
                        end
                    end else begin
                        retry_n = '0;
                        if (state == INIT_WAIT) begin
                            idx_n = idx + 1'b1;
                            if (idx) init_done_n = 1'b1;
                            if (!enable)  state_n = IDLE;
                            else if (idx) state_n = READ_ISSUE;
                            else          state_n = INIT_ISSUE;
                        end else begin
                            smp_load = 1'b1;
                            cnt_n    = '0;
                            state_n  = enable ? POLL_WAIT : IDLE;
                        end
                    end
                end
            end
            POLL_WAIT: begin
                if (!enable)                state_n = IDLE;
                else if (cnt == POLL_LAST)  state_n = READ_ISSUE;
                else                        cnt_n   = cnt + 1'b1;
            end
            ERROR: begin
                if (!enable) begin
                    state_n     = IDLE;
                    init_done_n = 1'b0;
                    retry_n     = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        // ISSUE states last one cycle, so entering one is the only time start is raised.
        // The command fields are held from that cycle until the next command is loaded.
        if (state_n == INIT_ISSUE) begin
            start_n  = 1'b1;
            write_n  = 1'b1;
            nbytes_n = 3'd1;
            addr_n   = idx_n ? 8'h31 : 8'h2D;
            wrdata_n = idx_n ? 8'h0B : 8'h08;
        end else if (state_n == READ_ISSUE) begin
            start_n  = 1'b1;
            write_n  = 1'b0;
            nbytes_n = 3'd6;
            addr_n   = 8'h32;
        end
    end

    // State, bookkeeping and registered command/status outputs
    always_ff @(posedge i2c_clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= 1'b0;
            retry     <= '0;
            cnt       <= '0;
            init_done <= 1'b0;
            start_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= 8'h00;
            nbytes_q  <= 3'd0;
            wrdata_q  <= 8'h00;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            retry     <= retry_n;
            cnt       <= cnt_n;
            init_done <= init_done_n;
            start_q   <= start_n;
            write_q   <= write_n;
            addr_q    <= addr_n;
            nbytes_q  <= nbytes_n;
            wrdata_q  <= wrdata_n;
            busy      <= (state_n == INIT_WAIT) || (state_n == READ_WAIT);
            error     <= (state_n == ERROR);
        end
    end

    // Sample capture one edge after a successful read. Samples hold until overwritten.
    always_ff @(posedge i2c_clock or negedge reset) begin
        if (!reset) begin
            x_out        <= '0;
            y_out        <= '0;
            z_out        <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= smp_load;
            if (smp_load) begin
                x_out <= $signed(drv.rdData[15:0]);
                y_out <= $signed(drv.rdData[31:16]);
                z_out <= $signed(drv.rdData[47:32]);
            end
        end
    end
endmodule

// File: tb/tb_i2c_accel_sequencer.sv
// Scoreboard bench for i2c_accel_sequencer.
// A transaction-level model turns each planned driver response into the commands and
// samples the sequencer must produce. A responder plays i2c_driver, and a monitor pops
// and compares expected values whenever start or sample_valid appears.
module tb_i2c_accel_sequencer;
    localparam int POLL = 5;
    localparam int MAXR = 3;

    typedef struct packed { logic wr; logic [7:0] addr; logic [2:0] nb; logic [7:0] wd; } cmd_t;
    typedef struct packed { logic [15:0] x; logic [15:0] y; logic [15:0] z; } smp_t;
    typedef struct packed { logic nack; logic [47:0] data; logic [7:0] lat; } rsp_t;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [15:0] x_out, y_out, z_out;
    logic        sample_valid, busy, error;

    i2c_accel_sequencer_if bus();

    i2c_accel_sequencer #(.DEVICE_ADDR(7'h53), .POLL_TICKS(POLL), .MAX_RETRY(MAXR)) dut (
        .i2c_clock(clk), .reset(reset), .enable(enable), .drv(bus),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .sample_valid(sample_valid), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0, cyc = 0;
    cmd_t exp_cmd[$];
    smp_t exp_smp[$];
    rsp_t rsp_q[$];
    cmd_t m_init_q[$];
    int   m_nacks;
    bit   m_init_done, m_error;
    smp_t m_last;
    bit   resp_active = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: init table first, then endless reads. More than MAXR
    // consecutive NACKs on one transaction means ERROR.
    task automatic model_clear();
        m_init_q.delete();
        m_init_q.push_back(cmd_t'{1'b1, 8'h2D, 3'd1, 8'h08});
        m_init_q.push_back(cmd_t'{1'b1, 8'h31, 3'd1, 8'h0B});
        m_init_done = 1'b0;
        m_nacks     = 0;
        m_error     = 1'b0;
    endtask

    task automatic add_rsp(input bit nack, input logic [47:0] data, input int lat);
        rsp_t r;
        cmd_t c;
        smp_t s;
        logic [7:0] b [6];
        c = m_init_done ? cmd_t'{1'b0, 8'h32, 3'd6, 8'h00} : m_init_q[0];
        exp_cmd.push_back(c);
        r.nack = nack;
        r.data = data;
        r.lat  = lat[7:0];
        rsp_q.push_back(r);
        if (nack) begin
            m_nacks++;
            if (m_nacks > MAXR) m_error = 1'b1;
        end else begin
            m_nacks = 0;
            if (!m_init_done) begin
                void'(m_init_q.pop_front());
                if (m_init_q.size() == 0) m_init_done = 1'b1;
            end else begin
                for (int i = 0; i < 6; i++) b[i] = data[8*i +: 8];
                s.x = {b[1], b[0]};
                s.y = {b[3], b[2]};
                s.z = {b[5], b[4]};
                exp_smp.push_back(s);
                m_last = s;
            end
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        return d[47:0];
    endfunction

    // Driver model: latch a response on start, answer with done after lat cycles
    initial begin
        rsp_t cur;
        int   wait_cnt;
        bus.done      = 1'b0;
        bus.ack_error = 1'b0;
        bus.rdData    = '0;
        wait_cnt      = 0;
        cur           = '0;
        forever begin
            @(negedge clk);
            bus.done      = 1'b0;
            bus.ack_error = 1'b0;
            if (!reset) begin
                resp_active = 1'b0;
            end else if (resp_active) begin
                wait_cnt--;
                if (wait_cnt <= 0) begin
                    bus.done      = 1'b1;
                    bus.ack_error = cur.nack;
                    bus.rdData    = cur.data;
                    resp_active   = 1'b0;
                end
            end else if (bus.start) begin
                if (rsp_q.size() > 0) cur = rsp_q.pop_front();
                else                  cur = rsp_t'{1'b0, 48'h0, 8'd1};
                wait_cnt    = int'(cur.lat);
                resp_active = 1'b1;
            end
        end
    end

    // Monitor: compare every start and every sample against the scoreboard
    initial begin
        bit   prev_start = 1'b0, gap_arm = 1'b0;
        int   gap_cyc = 0, sv_due = -10;
        cmd_t c;
        smp_t s;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset) begin
                prev_start = 1'b0;
                gap_arm    = 1'b0;
                sv_due     = -10;
            end else begin
                if (!enable) gap_arm = 1'b0;
                if (bus.start) begin
                    chk("start_width", {63'd0, prev_start}, 64'd0);
                    chk("busy_at_start", {63'd0, busy}, 64'd0);
                    chk("device_addr", {57'd0, bus.deviceAddr}, 64'h53);
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got addr %0h write %0b, expected no start (t=%0t)",
                                 bus.addr, bus.write, $time);
                    end else begin
                        c = exp_cmd.pop_front();
                        chk("cmd_write", {63'd0, bus.write}, {63'd0, c.wr});
                        chk("cmd_addr", {56'd0, bus.addr}, {56'd0, c.addr});
                        chk("cmd_numbytes", {61'd0, bus.numBytes}, {61'd0, c.nb});
                        if (c.wr) chk("cmd_wrdata", {56'd0, bus.wrData}, {56'd0, c.wd});
                    end
                    if (gap_arm && !bus.write) chk("poll_gap", 64'(cyc - gap_cyc), 64'(POLL + 1));
                    gap_arm = 1'b0;
                end
                if (bus.done) begin
                    chk("busy_at_done", {63'd0, busy}, 64'd1);
                    if (!bus.ack_error && !bus.write) begin
                        sv_due = cyc + 1;
                        if (enable) begin
                            gap_arm = 1'b1;
                            gap_cyc = cyc;
                        end
                    end
                end
                if (sample_valid || cyc == sv_due) begin
                    chk("sample_latency", {62'd0, sample_valid, cyc == sv_due}, 64'd3);
                    if (sample_valid) begin
                        if (exp_smp.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_sample: got %h %h %h, expected no sample", x_out, y_out, z_out);
                        end else begin
                            s = exp_smp.pop_front();
                            chk("x_out", {48'd0, x_out}, {48'd0, s.x});
                            chk("y_out", {48'd0, y_out}, {48'd0, s.y});
                            chk("z_out", {48'd0, z_out}, {48'd0, s.z});
                        end
                    end
                end
                prev_start = bus.start;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (rsp_q.size() == 0 && !resp_active && !bus.done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got %0d responses pending, expected 0", name, rsp_q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd"}, {bus.start, bus.write, bus.addr, bus.numBytes, bus.wrData}, 64'd0);
        chk({tag, "_xyz"}, {16'd0, x_out, y_out, z_out}, 64'd0);
        chk({tag, "_status"}, {61'd0, sample_valid, busy, error}, 64'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_cmd_q"}, 64'(exp_cmd.size()), 64'd0);
        chk({tag, "_smp_q"}, 64'(exp_smp.size()), 64'd0);
    endtask

    initial begin
        bit nack;
        int waited;
        reset  = 1'b0;
        enable = 1'b0;
        model_clear();
        settle(3);
        check_reset_outputs("reset");

        // Init with two NACKs on the first write, the fixed sample, then random polls.
        // Polls 3..5 NACK exactly MAXR times in a row, which must not raise error.
        add_rsp(1'b1, rnd48(), 1);
        add_rsp(1'b1, rnd48(), 2);
        add_rsp(1'b0, rnd48(), 1);
        add_rsp(1'b0, rnd48(), 3);
        add_rsp(1'b0, 48'h8000_ABCD_1234, 2);
        for (int i = 0; i < 10; i++) begin
            nack = (i >= 3 && i <= 5) ||
                   (i != 2 && i != 6 && $urandom_range(0, 3) == 0 && m_nacks < MAXR);
            add_rsp(nack, rnd48(), $urandom_range(1, 4));
        end
        add_rsp(1'b0, rnd48(), 1);
        reset  = 1'b1;
        enable = 1'b1;
        drain("run", 2000);
        enable = 1'b0;
        settle(10);
        check_drained("run");
        chk("run_error", {63'd0, error}, 64'd0);

        // Re-enable goes straight to a read. Four NACKs lead to ERROR and no further starts.
        for (int i = 0; i < MAXR + 1; i++) add_rsp(1'b1, rnd48(), $urandom_range(1, 3));
        enable = 1'b1;
        drain("nack", 500);
        settle(20);
        chk("err_flag", {63'd0, error}, {63'd0, m_error});
        chk("err_busy", {63'd0, busy}, 64'd0);
        chk("err_hold_xyz", {16'd0, x_out, y_out, z_out}, {16'd0, m_last});
        check_drained("err");
        enable = 1'b0;
        settle(3);
        chk("err_clear", {63'd0, error}, 64'd0);
        model_clear();

        // Reset asserted while the first init write is outstanding takes effect immediately
        add_rsp(1'b0, rnd48(), 40);
        enable = 1'b1;
        waited = 0;
        while (!busy && waited < 50) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("mid_init_busy", {63'd0, busy}, 64'd1);
        #1 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        rsp_q.delete();
        check_drained("async_reset");
        model_clear();
        enable = 1'b0;
        settle(3);
        reset = 1'b1;
        settle(2);

        // enable drops during READ_WAIT: the read still lands, and no new start is issued
        add_rsp(1'b0, rnd48(), 2);
        add_rsp(1'b0, rnd48(), 1);
        add_rsp(1'b0, rnd48(), 12);
        enable = 1'b1;
        waited = 0;
        while (!(bus.start && !bus.write) && waited < 200) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk("read_issue_seen", {63'd0, bus.start && !bus.write}, 64'd1);
        enable = 1'b0;
        drain("drop", 100);
        settle(20);
        check_drained("drop");
        chk("drop_hold_xyz", {16'd0, x_out, y_out, z_out}, {16'd0, m_last});

        // Re-enable skips init because init_done is kept
        add_rsp(1'b0, rnd48(), 2);
        enable = 1'b1;
        drain("reenable", 100);
        enable = 1'b0;
        settle(10);
        check_drained("reenable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
